// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: packs a little-endian byte stream into
// 32-bit words and writes them from address 0 until a halt-opcode word is stored.
module imem_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              overflow_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value so no branch can infer a latch.
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_RECV;
          byte_idx_d = 2'd0;
          addr_d     = '0;
          count_d    = '0;
        end
      end
      S_RECV: begin
        if (rx_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_q + COUNT_ONE;
        if (word_q[6:0] == 7'd0) begin
          state_d = S_DONE;
        end else if (addr_q == ADDR_LAST) begin
          state_d = S_ERR;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
    end
  end

  // Strobes decode straight from state, so reset cancels them asynchronously.
  assign rx_ready     = (state_q == S_RECV);
  assign imem_we      = (state_q == S_WRITE);
  assign busy         = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign overflow_err = (state_q == S_ERR);
  assign imem_addr    = addr_q;
  assign imem_wdata   = word_q;
  assign word_count   = count_q;

endmodule
